hamming74_byte_decoder: RTL and testbench

//  Receive-side counterpart of the nibble Hamming(7,4) encoder on the UART transit path.

---
 rtl/hamming_pkg.sv | 46 ++++
 rtl/hamming74_correct.sv | 37 +++
 rtl/hamming74_byte_decoder.sv | 227 ++++++++++++++++++++++
 tb/tb_hamming74_byte_decoder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// ---------------------------------------------------------------------------
// hamming_pkg
//   Shared definitions for the nibble Hamming(7,4) encoder/decoder pair.
//   Codeword bit i carries Hamming position i+1: {p1 p2 d1 p3 d2 d3 d4}
//   from bit 0 upwards. The POS_* constants are bit indices into a codeword.
//
//   Contents:
//     codeword_t  7-bit codeword
//     nibble_t    4-bit data nibble
//     POS_*       bit index of each Hamming position
//     phase_t     nibble phase of a codeword within a byte (PH_LO / PH_HI)
//     syndrome()  3-bit syndrome {s3,s2,s1}; non-zero value = erroneous position
// ---------------------------------------------------------------------------
package hamming_pkg;

    typedef logic [6:0] codeword_t;
    typedef logic [3:0] nibble_t;

    localparam int POS_P1 = 0;
    localparam int POS_P2 = 1;
    localparam int POS_D1 = 2;
    localparam int POS_P3 = 3;
    localparam int POS_D2 = 4;
    localparam int POS_D3 = 5;
    localparam int POS_D4 = 6;

    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } phase_t;

    // Each syndrome bit re-checks one parity group; together they spell the
    // 1-based position of a single flipped bit.
    function automatic logic [2:0] syndrome(input codeword_t code);
        logic s1;
        logic s2;
        logic s3;
        // NOTE: combinational code uses blocking '='; clocked state uses '<=' so
        // every flop samples the values that existed before the clock edge.
        s1 = code[POS_P1] ^ code[POS_D1] ^ code[POS_D2] ^ code[POS_D4];
        s2 = code[POS_P2] ^ code[POS_D1] ^ code[POS_D3] ^ code[POS_D4];
        s3 = code[POS_P3] ^ code[POS_D2] ^ code[POS_D3] ^ code[POS_D4];
        return {s3, s2, s1};
    endfunction

endpackage

// File: rtl/hamming74_correct.sv
// ---------------------------------------------------------------------------
// hamming74_correct
//   Purely combinational single-error corrector for one Hamming(7,4) codeword.
//   A non-zero syndrome flips the bit it points at; the data nibble is then
//   taken from positions {7,6,5,3}. A double error is silently mis-corrected.
//
//   Ports:
//     code    in  7  codeword, bit i = Hamming position i+1
//     nibble  out 4  corrected data nibble {d4,d3,d2,d1}
//     corr    out 1  a correction was applied (syndrome non-zero)
// ---------------------------------------------------------------------------
module hamming74_correct
    import hamming_pkg::*;
(
    input  logic [6:0] code,
    output logic [3:0] nibble,
    output logic       corr
);

    logic [2:0] synd;
    logic [6:0] flip;
    codeword_t  fixed;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        flip = '0;
        synd = syndrome(code);
        if (synd != 3'd0) begin
            flip = 7'd1 << (synd - 3'd1);
        end
        fixed  = code ^ flip;
        nibble = {fixed[POS_D4], fixed[POS_D3], fixed[POS_D2], fixed[POS_D1]};
        corr   = (synd != 3'd0);
    end

endmodule

// File: rtl/hamming74_byte_decoder.sv
// ---------------------------------------------------------------------------
// hamming74_byte_decoder
//   Receive side of the nibble Hamming(7,4) link. Accepts 7-bit codewords on
//   a valid/ready handshake, corrects single-bit errors, pairs the decoded
//   nibbles (low first) into bytes and queues them for the byte consumer.
//
//   Datapath:
//     code_in -> hamming74_correct -> stage-1 register (nibble, corr, phase)
//     stage-1 LO -> low-nibble holder
//     stage-1 HI -> {hi,lo} pushed into the byte FIFO
//     FIFO memory -> registered head (byte_out / byte_err / byte_valid)
//   A HI codeword accepted at edge N appears on byte_out after edge N+2.
//
//   Ports:
//     clk         in   1          rising-edge clock
//     reset       in   1          asynchronous, active-low reset
//     code_in     in   7          codeword, bit i = Hamming position i+1
//     code_valid  in   1          code_in valid
//     code_ready  out  1          codeword can be accepted this cycle
//     resync      in   1          force phase to LO and drop the held low nibble
//     byte_out    out  8          head byte {hi,lo}
//     byte_err    out  2          {hi corrected, lo corrected} for byte_out
//     byte_valid  out  1          byte_out valid
//     byte_ready  in   1          consumer takes byte_out
//     err_cnt     out  ERR_CNT_W  saturating count of corrected codewords
//
//   Build option:
//     HAM_ERR_CNT_EN  when defined, err_cnt counts corrected codewords;
//                     otherwise err_cnt is constant zero.
// ---------------------------------------------------------------------------
module hamming74_byte_decoder
    import hamming_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           code_in,
    input  logic                 code_valid,
    output logic                 code_ready,
    input  logic                 resync,
    output logic [7:0]           byte_out,
    output logic [1:0]           byte_err,
    output logic                 byte_valid,
    input  logic                 byte_ready,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [1:0] err;
        logic [7:0] data;
    } entry_t;

    // Held low after reset until the first edge so code_ready stays 0 in reset.
    logic             run;
    logic             accept;

    phase_t           phase;
    phase_t           phase_nxt;
    phase_t           acc_phase;

    nibble_t          dec_nib;
    logic             dec_corr;

    logic             s1_valid;
    phase_t           s1_phase;
    nibble_t          s1_nib;
    logic             s1_corr;

    nibble_t          lo_nib;
    logic             lo_corr;

    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] mem_count;

    logic             push;
    logic             load_out;
    logic [CNT_W:0]   occupancy;

    hamming74_correct u_correct (
        .code   (code_in),
        .nibble (dec_nib),
        .corr   (dec_corr)
    );

    assign accept   = code_valid && code_ready;
    assign push     = s1_valid && (s1_phase == PH_HI);
    // The head register refills whenever it is empty or being consumed.
    assign load_out = (mem_count != '0) && (!byte_valid || byte_ready);

    // Bytes already queued (memory + head) plus the byte that stage 1 is about
    // to push. Keeping this below the depth means a push never finds it full.
    assign occupancy  = (CNT_W + 1)'(mem_count) + (CNT_W + 1)'(byte_valid)
                      + (CNT_W + 1)'(push);
    assign code_ready = run && (occupancy < DEPTH_LIM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // ---------------- phase FSM ----------------
    always_comb begin
        // A codeword arriving together with resync is always a low nibble.
        acc_phase = resync ? PH_LO : phase;
        phase_nxt = phase;
        if (accept) begin
            phase_nxt = (acc_phase == PH_LO) ? PH_HI : PH_LO;
        end else if (resync) begin
            phase_nxt = PH_LO;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= PH_LO;
        end else begin
            phase <= phase_nxt;
        end
    end

    // ---------------- stage 1 ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_phase <= PH_LO;
            s1_nib   <= '0;
            s1_corr  <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_phase <= acc_phase;
                s1_nib   <= dec_nib;
                s1_corr  <= dec_corr;
            end
        end
    end

    // ---------------- low-nibble holder ----------------
    // resync wins over a LO nibble leaving stage 1 on the same edge, so that
    // nibble is dropped too.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lo_nib  <= '0;
            lo_corr <= 1'b0;
        end else if (resync) begin
            lo_nib  <= '0;
            lo_corr <= 1'b0;
        end else if (s1_valid && (s1_phase == PH_LO)) begin
            lo_nib  <= s1_nib;
            lo_corr <= s1_corr;
        end
    end

    // ---------------- byte FIFO ----------------
    // NOTE: the storage array has no reset; only pointers, count and the head
    // register are reset, and stale entries are never visible on byte_out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry_t'({s1_corr, lo_corr, s1_nib, lo_nib});
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (load_out) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, load_out})
                2'b10:   mem_count <= mem_count + CNT_W'(1);
                2'b01:   mem_count <= mem_count - CNT_W'(1);
                default: mem_count <= mem_count;
            endcase
        end
    end

    // Registered head: holds steady while byte_valid && !byte_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_valid <= 1'b0;
            byte_out   <= '0;
            byte_err   <= '0;
        end else if (load_out) begin
            byte_valid <= 1'b1;
            byte_out   <= mem[rd_ptr].data;
            byte_err   <= mem[rd_ptr].err;
        end else if (byte_ready) begin
            byte_valid <= 1'b0;
        end
    end

    // ---------------- corrected-error counter ----------------
`ifdef HAM_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= '0;
        end else if (s1_valid && s1_corr && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_hamming74_byte_decoder.sv
// ---------------------------------------------------------------------------
// tb_hamming74_byte_decoder
//   Directed and randomized checks of hamming74_byte_decoder. Expected bytes
//   come from a reference that encodes nibbles with the Hamming parity rules
//   and pairs accepted nibbles low-then-high into a queue of expected bytes.
//   Honours HAM_ERR_CNT_EN for the expected err_cnt value.
// ---------------------------------------------------------------------------
module tb_hamming74_byte_decoder;

    localparam int ERR_W   = 8;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk;
    logic             reset;
    logic [6:0]       code_in;
    logic             code_valid;
    logic             code_ready;
    logic             resync;
    logic [7:0]       byte_out;
    logic [1:0]       byte_err;
    logic             byte_valid;
    logic             byte_ready;
    logic [ERR_W-1:0] err_cnt;

    hamming74_byte_decoder #(
        .FIFO_DEPTH (2),
        .ERR_CNT_W  (ERR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .resync     (resync),
        .byte_out   (byte_out),
        .byte_err   (byte_err),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .err_cnt    (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: {err[1:0], byte[7:0]} in expected arrival order.
    logic [9:0] exp_q [$];
    bit         m_hi;
    logic [3:0] m_lo;
    logic       m_lo_corr;
    int         corr_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] encode(input logic [3:0] nib);
        logic d1, d2, d3, d4;
        d1 = nib[0];
        d2 = nib[1];
        d3 = nib[2];
        d4 = nib[3];
        // positions 1..7 = p1 p2 d1 p3 d2 d3 d4
        return {d4, d3, d2, d2 ^ d3 ^ d4, d1, d1 ^ d3 ^ d4, d1 ^ d2 ^ d4};
    endfunction

    function automatic int exp_err();
`ifdef HAM_ERR_CNT_EN
        return (corr_count > ERR_MAX) ? ERR_MAX : corr_count;
`else
        return 0;
`endif
    endfunction

    task automatic model_accept(input logic [3:0] nib, input logic corr);
        if (corr) corr_count++;
        if (!m_hi) begin
            m_lo      = nib;
            m_lo_corr = corr;
            m_hi      = 1'b1;
        end else begin
            exp_q.push_back({corr, m_lo_corr, nib, m_lo});
            m_hi = 1'b0;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers one codeword for at most max_wait cycles; no reference update.
    task automatic try_send(input logic [6:0] code, input int max_wait, output bit accepted);
        accepted   = 1'b0;
        code_in    = code;
        code_valid = 1'b1;
        for (int i = 0; i < max_wait; i++) begin
            if (code_ready) begin
                accepted = 1'b1;
                break;
            end
            step(1);
        end
        if (accepted) step(1);
        code_valid = 1'b0;
    endtask

    task automatic send(input logic [6:0] code, input logic [3:0] nib, input logic corr);
        bit acc;
        try_send(code, 40, acc);
        check("accept_within_budget", 32'(acc), 32'd1);
        if (acc) model_accept(nib, corr);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && !byte_valid) break;
            step(1);
        end
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_valid_low"}, 32'(byte_valid), 32'd0);
    endtask

    // Output monitor: every popped byte is compared with the reference queue,
    // and a stalled head must not change.
    bit         held;
    logic [7:0] held_byte;
    logic [1:0] held_err;

    always @(negedge clk) begin
        if (reset) begin
            if (held) begin
                check("stall_valid", 32'(byte_valid), 32'd1);
                check("stall_byte", 32'(byte_out), 32'(held_byte));
                check("stall_err", 32'(byte_err), 32'(held_err));
            end
            if (byte_valid && byte_ready) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 32'(byte_valid), 32'd0);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    check("pop_byte", 32'(byte_out), 32'(e[7:0]));
                    check("pop_err", 32'(byte_err), 32'(e[9:8]));
                end
            end
            held      = byte_valid && !byte_ready;
            held_byte = byte_out;
            held_err  = byte_err;
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         acc;
        bit         rs;
        logic [3:0] nib;
        logic [6:0] code;
        logic       corr;
        int         pos;

        m_hi       = 1'b0;
        m_lo       = '0;
        m_lo_corr  = 1'b0;
        corr_count = 0;
        code_in    = '0;
        code_valid = 1'b0;
        resync     = 1'b0;
        byte_ready = 1'b0;
        reset      = 1'b1;
        #1 reset   = 1'b0;
        #1;

        // ---- reset state ----
        check("rst_code_ready", 32'(code_ready), 32'd0);
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_byte_out", 32'(byte_out), 32'd0);
        check("rst_byte_err", 32'(byte_err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        step(2);
        reset = 1'b1;
        check("release_ready_low", 32'(code_ready), 32'd0);
        step(1);
        check("release_ready_high", 32'(code_ready), 32'd1);

        // ---- 1: clean pair and latency ----
        byte_ready = 1'b1;
        send(7'h2D, 4'h5, 1'b0);
        send(7'h52, 4'hA, 1'b0);
        check("t1_lat_edge0", 32'(byte_valid), 32'd0);
        step(1);
        check("t1_lat_edge1", 32'(byte_valid), 32'd0);
        step(1);
        check("t1_lat_edge2", 32'(byte_valid), 32'd1);
        check("t1_byte", 32'(byte_out), 32'hA5);
        check("t1_err", 32'(byte_err), 32'd0);
        wait_drain("t1");

        // ---- 2: single-bit correction ----
        send(7'h3D, 4'h5, 1'b1);
        send(7'h52, 4'hA, 1'b0);
        step(2);
        check("t2_byte", 32'(byte_out), 32'hA5);
        check("t2_err", 32'(byte_err), 32'd1);
        check("t2_err_cnt", 32'(err_cnt), 32'(exp_err()));
        wait_drain("t2");

        // ---- 3: backpressure, FIFO full ----
        byte_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            send(7'h00, 4'h0, 1'b0);
            send(7'h7F, 4'hF, 1'b0);
        end
        try_send(7'h00, 6, acc);
        check("t3_blocked", 32'(acc), 32'd0);
        check("t3_ready_low", 32'(code_ready), 32'd0);
        check("t3_head_valid", 32'(byte_valid), 32'd1);
        check("t3_head_byte", 32'(byte_out), 32'hF0);
        byte_ready = 1'b1;
        wait_drain("t3");

        // ---- 4: resync drops held low nibble ----
        send(7'h2D, 4'h5, 1'b0);
        resync = 1'b1;
        step(1);
        resync = 1'b0;
        m_hi   = 1'b0;
        send(7'h00, 4'h0, 1'b0);
        send(7'h7F, 4'hF, 1'b0);
        step(2);
        check("t4_byte", 32'(byte_out), 32'hF0);
        wait_drain("t4");

        // ---- 5: reset mid-operation ----
        byte_ready = 1'b0;
        send(7'h00, 4'h0, 1'b0);
        send(7'h7F, 4'hF, 1'b0);
        send(7'h2D, 4'h5, 1'b0);
        step(2);
        check("t5_pre_valid", 32'(byte_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t5_rst_valid", 32'(byte_valid), 32'd0);
        check("t5_rst_byte", 32'(byte_out), 32'd0);
        check("t5_rst_err", 32'(byte_err), 32'd0);
        check("t5_rst_ready", 32'(code_ready), 32'd0);
        check("t5_rst_err_cnt", 32'(err_cnt), 32'd0);
        exp_q.delete();
        m_hi       = 1'b0;
        corr_count = 0;
        @(posedge clk);
        #1 reset = 1'b1;
        step(1);
        check("t5_ready_after", 32'(code_ready), 32'd1);
        byte_ready = 1'b1;
        send(7'h7F, 4'hF, 1'b0);
        send(7'h00, 4'h0, 1'b0);
        step(2);
        check("t5_byte", 32'(byte_out), 32'h0F);
        wait_drain("t5");

        // ---- randomized traffic ----
        for (int i = 0; i < 200; i++) begin
            nib  = 4'($urandom_range(15));
            code = encode(nib);
            corr = 1'($urandom_range(1));
            if (corr) begin
                pos       = int'($urandom_range(6));
                code[pos] = ~code[pos];
            end
            byte_ready = ($urandom_range(3) != 0);
            rs         = ($urandom_range(15) == 0);
            resync     = rs;
            try_send(code, 4, acc);
            resync = 1'b0;
            if (rs) m_hi = 1'b0;
            if (acc) begin
                model_accept(nib, corr);
            end else begin
                byte_ready = 1'b1;
                send(code, nib, corr);
            end
            if ($urandom_range(3) == 0) step(1);
        end
        byte_ready = 1'b1;
        wait_drain("rand");
        check("rand_err_cnt", 32'(err_cnt), 32'(exp_err()));

        // ---- 6: counter saturation ----
        for (int i = 0; i < 270; i++) begin
            logic [6:0] mask;
            nib  = 4'($urandom_range(15));
            mask = 7'd1 << $urandom_range(6);
            send(encode(nib) ^ mask, nib, 1'b1);
        end
        wait_drain("sat");
        step(2);
        check("sat_err_cnt", 32'(err_cnt), 32'(exp_err()));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
